// File: rtl/pc_fetch.sv
// Fetch stage: program counter, instruction register and redirect handling.
// Jump beats taken branch beats stall; HALTED freezes everything until reset.
module pc_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          OFFSET_W = 6
) (
  input  logic                clk_pi,
  input  logic                reset_pi,
  input  logic                stall_pi,
  input  logic                halt_pi,
  input  logic                is_branch_taken_pi,
  input  logic [15:0]         branch_pc_pi,
  input  logic [OFFSET_W-1:0] branch_offset_pi,
  input  logic                jump_pi,
  input  logic [15:0]         jump_target_pi,
  input  logic [15:0]         imem_data_pi,
  output logic [15:0]         pc_po,
  output logic [15:0]         instr_po,
  output logic [15:0]         instr_pc_po,
  output logic                instr_valid_po,
  output logic                halted_po,
  output logic [15:0]         taken_count_po
);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  logic [15:0] offset_ext;
  logic [15:0] branch_target;
  logic [15:0] count_inc;

  assign offset_ext    = {{(16-OFFSET_W){branch_offset_pi[OFFSET_W-1]}}, branch_offset_pi};
  assign branch_target = branch_pc_pi + 16'd1 + offset_ext;
  assign count_inc     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    count_d    = count_q;
    case (state_q)
      ST_RUN: begin
        if (halt_pi) begin
          state_d = ST_HALTED;
          valid_d = 1'b0;
        end else if (jump_pi) begin
          pc_d    = jump_target_pi;
          instr_d = 16'h0000;
          valid_d = 1'b0;
          count_d = count_inc;
        end else if (is_branch_taken_pi) begin
          pc_d    = branch_target;
          instr_d = 16'h0000;
          valid_d = 1'b0;
          count_d = count_inc;
        end else if (!stall_pi) begin
          instr_d    = imem_data_pi;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + 16'd1;
        end
      end
      // HALTED holds every register; only reset leaves it.
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      valid_q    <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign pc_po          = pc_q;
  assign instr_po       = instr_q;
  assign instr_pc_po    = instr_pc_q;
  assign instr_valid_po = valid_q;
  assign halted_po      = (state_q == ST_HALTED);
  assign taken_count_po = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: expected outputs are queued before each
// clock step and popped against the DUT one time unit after the edge.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, halt, taken, jump;
  logic [15:0] branch_pc, jump_target, imem_data;
  logic [5:0]  branch_offset;
  logic [15:0] pc, instr, instr_pc, count;
  logic        valid, halted;

  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(16'h0010), .OFFSET_W(6)) dut (
    .clk_pi(clk),
    .reset_pi(rst),
    .stall_pi(stall),
    .halt_pi(halt),
    .is_branch_taken_pi(taken),
    .branch_pc_pi(branch_pc),
    .branch_offset_pi(branch_offset),
    .jump_pi(jump),
    .jump_target_pi(jump_target),
    .imem_data_pi(imem_data),
    .pc_po(pc),
    .instr_po(instr),
    .instr_pc_po(instr_pc),
    .instr_valid_po(valid),
    .halted_po(halted),
    .taken_count_po(count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h but expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic push6(input logic [15:0] e_pc, input logic [15:0] e_instr,
                       input logic [15:0] e_ipc, input logic e_valid,
                       input logic e_halted, input logic [15:0] e_count);
    exp_q.push_back(e_pc);
    exp_q.push_back(e_instr);
    exp_q.push_back(e_ipc);
    exp_q.push_back({15'd0, e_valid});
    exp_q.push_back({15'd0, e_halted});
    exp_q.push_back(e_count);
  endtask

  task automatic chk6(input string tag);
    chk({tag, ".pc"}, pc);
    chk({tag, ".instr"}, instr);
    chk({tag, ".instr_pc"}, instr_pc);
    chk({tag, ".valid"}, {15'd0, valid});
    chk({tag, ".halted"}, {15'd0, halted});
    chk({tag, ".count"}, count);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; halt = 1'b0; taken = 1'b0; jump = 1'b0;
    branch_pc = 16'h0000; branch_offset = 6'd0; jump_target = 16'h0000;
    imem_data = 16'h0000;
    #1;
    push6(16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk6("reset");
    step();
    rst = 1'b0;

    // Sequential fetch of three words.
    imem_data = 16'h1111;
    push6(16'h0011, 16'h1111, 16'h0010, 1'b1, 1'b0, 16'h0000);
    step(); chk6("seq0");
    imem_data = 16'h2222;
    push6(16'h0012, 16'h2222, 16'h0011, 1'b1, 1'b0, 16'h0000);
    step(); chk6("seq1");
    imem_data = 16'h3333;
    push6(16'h0013, 16'h3333, 16'h0012, 1'b1, 1'b0, 16'h0000);
    step(); chk6("seq2");

    // Taken branch with offset -3 from 0x0020, then a not-taken cycle.
    branch_pc = 16'h0020; branch_offset = 6'b111101; taken = 1'b1;
    imem_data = 16'h4444;
    push6(16'h001E, 16'h0000, 16'h0012, 1'b0, 1'b0, 16'h0001);
    step(); chk6("br_neg3");
    taken = 1'b0; imem_data = 16'h5555;
    push6(16'h001F, 16'h5555, 16'h001E, 1'b1, 1'b0, 16'h0001);
    step(); chk6("br_not");

    // Offset extremes: +31 and -32 (the latter wraps below zero).
    branch_pc = 16'h0030; branch_offset = 6'b011111; taken = 1'b1;
    push6(16'h0050, 16'h0000, 16'h001E, 1'b0, 1'b0, 16'h0002);
    step(); chk6("br_p31");
    branch_pc = 16'h0000; branch_offset = 6'b100000;
    push6(16'hFFE1, 16'h0000, 16'h001E, 1'b0, 1'b0, 16'h0003);
    step(); chk6("br_m32");

    // Stall holds fetch state for two cycles.
    taken = 1'b0; stall = 1'b1; imem_data = 16'h6666;
    push6(16'hFFE1, 16'h0000, 16'h001E, 1'b0, 1'b0, 16'h0003);
    step(); chk6("stall0");
    push6(16'hFFE1, 16'h0000, 16'h001E, 1'b0, 1'b0, 16'h0003);
    step(); chk6("stall1");

    // Jump beats taken branch and stall together; count moves once.
    jump = 1'b1; jump_target = 16'h0100;
    taken = 1'b1; branch_pc = 16'h0020; branch_offset = 6'b111101;
    push6(16'h0100, 16'h0000, 16'h001E, 1'b0, 1'b0, 16'h0004);
    step(); chk6("prio");
    jump = 1'b0; taken = 1'b0; stall = 1'b0; imem_data = 16'h7777;
    push6(16'h0101, 16'h7777, 16'h0100, 1'b1, 1'b0, 16'h0004);
    step(); chk6("after_jump");

    // PC wrap from 0xFFFF.
    jump = 1'b1; jump_target = 16'hFFFF;
    push6(16'hFFFF, 16'h0000, 16'h0100, 1'b0, 1'b0, 16'h0005);
    step(); chk6("jmp_ffff");
    jump = 1'b0; imem_data = 16'h8888;
    push6(16'h0000, 16'h8888, 16'hFFFF, 1'b1, 1'b0, 16'h0005);
    step(); chk6("wrap");

    // Halt, then redirects and fetches are ignored.
    halt = 1'b1; imem_data = 16'h9999;
    push6(16'h0000, 16'h8888, 16'hFFFF, 1'b0, 1'b1, 16'h0005);
    step(); chk6("halt");
    halt = 1'b0; jump = 1'b1; jump_target = 16'h0200;
    push6(16'h0000, 16'h8888, 16'hFFFF, 1'b0, 1'b1, 16'h0005);
    step(); chk6("halt_jump");
    jump = 1'b0; taken = 1'b1;
    push6(16'h0000, 16'h8888, 16'hFFFF, 1'b0, 1'b1, 16'h0005);
    step(); chk6("halt_br");
    taken = 1'b0;
    push6(16'h0000, 16'h8888, 16'hFFFF, 1'b0, 1'b1, 16'h0005);
    step(); chk6("halt_seq");

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    push6(16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk6("async_rst");
    step();
    rst = 1'b0; imem_data = 16'hABCD;
    push6(16'h0011, 16'hABCD, 16'h0010, 1'b1, 1'b0, 16'h0000);
    step(); chk6("run_after_rst");

    // Counter saturation over 65537 back-to-back redirects.
    jump = 1'b1; jump_target = 16'h0040;
    repeat (65534) @(posedge clk);
    #1;
    push6(16'h0040, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'hFFFE);
    chk6("sat_fffe");
    repeat (3) @(posedge clk);
    #1;
    push6(16'h0040, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'hFFFF);
    chk6("sat_ffff");
    jump = 1'b0;

    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL leftover: observed %0d queued expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
